// File: rtl/hazard_stall_control.sv
// Stall/flush controller for the 5-stage pipeline. It covers the hazards the
// forwarding unit cannot resolve: load-use (FD/PC hold plus a DX bubble),
// taken-branch wrong-path squash (FD and DX flushed), and multi-cycle
// mult/div sequencing via an IDLE/BUSY/DONE handshake with the multdiv unit.
module hazard_stall_control #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  input  logic        branch_taken,
  input  logic        multdiv_rdy,
  input  logic        multdiv_exception,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        nop_dx,
  output logic        nop_xm,
  output logic        flush_fd,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        md_result_sel,
  output logic        md_exception,
  output logic        md_busy,
  output logic        md_error
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Last BUSY count before the multdiv unit is declared hung.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  md_state_t        state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             exc_q, exc_nxt;
  logic             err_q, err_nxt;
  logic             md_start;

  // Instruction field decode.
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, fd_alu;
  logic [4:0] dx_op, dx_rd, dx_alu;
  assign fd_op  = fd_insn[31:27];
  assign fd_rd  = fd_insn[26:22];
  assign fd_rs  = fd_insn[21:17];
  assign fd_rt  = fd_insn[16:12];
  assign fd_alu = fd_insn[6:2];
  assign dx_op  = dx_insn[31:27];
  assign dx_rd  = dx_insn[26:22];
  assign dx_alu = dx_insn[6:2];

  // Shamt, low bits and DX source fields play no part in hazard detection.
  logic unused_fields;
  assign unused_fields = ^{fd_insn[11:7], fd_insn[1:0], dx_insn[21:7], dx_insn[1:0]};

  logic dx_is_lw, dx_is_mul, dx_is_div;
  assign dx_is_lw  = (dx_op == OP_LW);
  assign dx_is_mul = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
  assign dx_is_div = (dx_op == OP_RTYPE) && (dx_alu == ALU_DIV);

  // Which FD operand slots are real register reads. sw's rd is store data and
  // is deliberately excluded: the W->M bypass supplies it after a lw.
  logic fd_uses_rs, fd_uses_rt, fd_uses_rd;
  assign fd_uses_rs = (fd_op == OP_RTYPE) || (fd_op == OP_ADDI) || (fd_op == OP_LW) ||
                      (fd_op == OP_SW) || (fd_op == OP_BNE) || (fd_op == OP_BLT);
  assign fd_uses_rt = (fd_op == OP_RTYPE) && (fd_alu[4:1] != 4'b0010);
  assign fd_uses_rd = (fd_op == OP_BNE) || (fd_op == OP_BLT) || (fd_op == OP_JR);

  // A taken branch makes the FD instruction wrong-path, so its hazard is void.
  logic lu;
  assign lu = dx_is_lw && (dx_rd != 5'd0) && !branch_taken &&
              ((fd_uses_rs && (fd_rs == dx_rd)) ||
               (fd_uses_rt && (fd_rt == dx_rd)) ||
               (fd_uses_rd && (fd_rd == dx_rd)));

  // Multdiv FSM state, BUSY counter, latched exception and sticky timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      exc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      exc_q   <= exc_nxt;
      err_q   <= err_nxt;
    end
  end

  // Multdiv next-state: start from IDLE only, finish on rdy or timeout.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    exc_nxt   = exc_q;
    err_nxt   = err_q;
    md_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dx_is_mul || dx_is_div) begin
          md_start  = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = '0;
          exc_nxt   = 1'b0;
        end
      end
      BUSY: begin
        if (multdiv_rdy) begin
          state_nxt = DONE;
          exc_nxt   = multdiv_exception;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = DONE;
          exc_nxt   = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output merge: OR of load-use, flush and FSM terms; DX bubble is dropped
  // while DX is being held.
  always_comb begin
    stall_pc      = 1'b0;
    stall_fd      = 1'b0;
    stall_dx      = 1'b0;
    nop_dx        = 1'b0;
    nop_xm        = 1'b0;
    flush_fd      = 1'b0;
    ctrl_mult     = 1'b0;
    ctrl_div      = 1'b0;
    md_result_sel = 1'b0;
    md_exception  = 1'b0;
    md_busy       = 1'b0;
    md_error      = err_q;
    if (state_q == BUSY) begin
      stall_pc = 1'b1;
      stall_fd = 1'b1;
      stall_dx = 1'b1;
      nop_xm   = 1'b1;
      md_busy  = 1'b1;
    end
    if (state_q == DONE) begin
      md_result_sel = 1'b1;
      md_exception  = exc_q;
    end
    if (lu) begin
      stall_pc = 1'b1;
      stall_fd = 1'b1;
    end
    flush_fd  = branch_taken;
    nop_dx    = (lu || branch_taken) && !stall_dx;
    ctrl_mult = md_start && dx_is_mul && !reset;
    ctrl_div  = md_start && dx_is_div && !reset;
  end

endmodule

// File: tb/tb_hazard_stall_control.sv
// Bench for hazard_stall_control: directed scenarios followed by random
// instruction streams, checked cycle by cycle against a behavioural model.
module tb_hazard_stall_control;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fd_insn = '0;
  logic [31:0] dx_insn = '0;
  logic        branch_taken = 1'b0;
  logic        multdiv_rdy = 1'b0;
  logic        multdiv_exception = 1'b0;
  logic        stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, flush_fd;
  logic        ctrl_mult, ctrl_div, md_result_sel, md_exception, md_busy, md_error;

  localparam int TIMEOUT = 40;

  hazard_stall_control #(.MD_TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .branch_taken(branch_taken), .multdiv_rdy(multdiv_rdy),
    .multdiv_exception(multdiv_exception),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_dx(stall_dx),
    .nop_dx(nop_dx), .nop_xm(nop_xm), .flush_fd(flush_fd),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .md_result_sel(md_result_sel),
    .md_exception(md_exception), .md_busy(md_busy), .md_error(md_error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int busy_seen = 0;

  // Reference model of the multiply/divide unit as seen by the pipeline.
  bit m_op_running = 0;   // an op was started and has not finished
  int m_waited     = 0;   // cycles the running op has spent waiting
  bit m_result_now = 0;   // the finished op's result is in X this cycle
  bit m_result_exc = 0;
  bit m_hung       = 0;   // a timeout has ever happened since reset

  localparam logic [31:0] ADD_7_5_3 = 32'h01CA3000;
  localparam logic [31:0] LW_5_2    = 32'h41440000;
  localparam logic [31:0] SW_5_6    = 32'h394C0000;
  localparam logic [31:0] SW_8_5    = 32'h3A0A0000;
  localparam logic [31:0] MUL_4_1_2 = 32'h01022018;
  localparam logic [31:0] LW_0_2    = {5'b01000, 5'd0, 5'd2, 17'd0};
  localparam logic [31:0] ADD_7_0_3 = {5'b00000, 5'd7, 5'd0, 5'd3, 12'd0};
  localparam logic [31:0] DIV_6_1_2 = {5'b00000, 5'd6, 5'd1, 5'd2, 5'd0, 5'b00111, 2'b00};

  function automatic bit is_mul(logic [31:0] i);
    return i[31:27] == 5'd0 && i[6:2] == 5'd6;
  endfunction

  function automatic bit is_div(logic [31:0] i);
    return i[31:27] == 5'd0 && i[6:2] == 5'd7;
  endfunction

  // Does instruction f actually read register r as a source operand?
  function automatic bit reads_reg(logic [31:0] f, logic [4:0] r);
    logic [4:0] op;
    bit rs_src, rt_src, rd_src;
    op = f[31:27];
    rs_src = op inside {5'd0, 5'd5, 5'd8, 5'd7, 5'd2, 5'd6};
    rt_src = (op == 5'd0) && !(f[6:2] inside {5'd4, 5'd5});
    rd_src = op inside {5'd2, 5'd6, 5'd4};
    return (rs_src && f[21:17] == r) || (rt_src && f[16:12] == r) ||
           (rd_src && f[26:22] == r);
  endfunction

  function automatic logic [31:0] rnd_insn();
    logic [4:0] op, alu;
    case ($urandom_range(0, 9))
      0, 1:    op = 5'd0;
      2:       op = 5'd5;
      3:       op = 5'd7;
      4, 5:    op = 5'd8;
      6:       op = 5'd2;
      7:       op = 5'd6;
      8:       op = 5'd4;
      default: op = 5'($urandom_range(0, 31));
    endcase
    case ($urandom_range(0, 5))
      0:       alu = 5'd0;
      1:       alu = 5'd2;
      2:       alu = 5'd4;
      3:       alu = 5'd5;
      4:       alu = 5'd6;
      default: alu = 5'd7;
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), alu, 2'b00};
  endfunction

  // One clock cycle: apply inputs, check outputs mid-cycle, then advance the model.
  task automatic cyc(input logic [31:0] fd, input logic [31:0] dx, input logic bt,
                     input logic rdy, input logic exc, input logic rst, input string tag);
    logic [11:0] obs, exp;
    bit hazard, idle;
    fd_insn = fd;
    dx_insn = dx;
    branch_taken = bt;
    multdiv_rdy = rdy;
    multdiv_exception = exc;
    reset = rst;
    #3;
    hazard = (dx[31:27] == 5'd8) && (dx[26:22] != 5'd0) && reads_reg(fd, dx[26:22]) && !bt;
    idle = !m_op_running && !m_result_now;
    exp = {hazard || m_op_running, hazard || m_op_running, m_op_running,
           (hazard || bt) && !m_op_running, m_op_running, bt,
           idle && !rst && is_mul(dx), idle && !rst && is_div(dx),
           m_result_now, m_result_now && m_result_exc, m_op_running, m_hung};
    obs = {stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, flush_fd,
           ctrl_mult, ctrl_div, md_result_sel, md_exception, md_busy, md_error};
    if (md_busy === 1'b1) busy_seen++;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b (pc fd dx nopdx nopxm flush mul div sel exc busy err)",
             tag, obs, exp);
    end
    @(posedge clock);
    #1;
    if (rst) begin
      m_op_running = 0; m_waited = 0; m_result_now = 0; m_result_exc = 0; m_hung = 0;
    end else if (m_op_running) begin
      m_waited++;
      if (rdy) begin
        m_op_running = 0; m_result_now = 1; m_result_exc = exc;
      end else if (m_waited == TIMEOUT) begin
        m_op_running = 0; m_result_now = 1; m_result_exc = 1; m_hung = 1;
      end
    end else if (m_result_now) begin
      m_result_now = 0;
    end else if (is_mul(dx) || is_div(dx)) begin
      m_op_running = 1; m_waited = 0;
    end
  endtask

  initial begin
    logic [31:0] cur_dx;
    logic        bt;
    // Bring the DUT out of its unknown power-up state.
    reset = 1'b1;
    @(posedge clock);
    #1;
    cyc(32'd0, 32'd0, 0, 0, 0, 1, "reset_hold");
    cyc(32'd0, 32'd0, 0, 0, 0, 0, "after_reset");

    // Load-use and its exemptions.
    cyc(ADD_7_5_3, LW_5_2, 0, 0, 0, 0, "lu_add");
    cyc(ADD_7_5_3, 32'd0, 0, 0, 0, 0, "lu_released");
    cyc(SW_5_6, LW_5_2, 0, 0, 0, 0, "sw_data_no_stall");
    cyc(SW_8_5, LW_5_2, 0, 0, 0, 0, "sw_addr_stall");
    cyc(ADD_7_0_3, LW_0_2, 0, 0, 0, 0, "lw_r0_no_stall");
    cyc(ADD_7_5_3, LW_5_2, 1, 0, 0, 0, "flush_over_lu");

    // Multiply completing after 16 busy cycles.
    busy_seen = 0;
    cyc(32'd0, MUL_4_1_2, 0, 0, 0, 0, "mul_start");
    for (int i = 1; i <= 16; i++) cyc(ADD_7_5_3, MUL_4_1_2, 0, (i == 16), 0, 0, "mul_busy");
    cyc(ADD_7_5_3, MUL_4_1_2, 0, 0, 0, 0, "mul_done");
    cyc(ADD_7_5_3, 32'd0, 0, 0, 0, 0, "mul_idle");
    total++;
    assert (busy_seen == 16) else begin
      bad++;
      $error("FAIL mul_busy_len got=%0d exp=%0d", busy_seen, 16);
    end

    // Divide that never completes: timeout, sticky error until reset.
    cyc(32'd0, DIV_6_1_2, 0, 0, 0, 0, "div_to_start");
    for (int i = 1; i <= TIMEOUT; i++) cyc(32'd0, DIV_6_1_2, 0, 0, 0, 0, "div_to_busy");
    cyc(32'd0, DIV_6_1_2, 0, 0, 0, 0, "div_to_done");
    for (int i = 0; i < 3; i++) cyc(32'd0, 32'd0, 0, 0, 0, 0, "err_sticky");
    cyc(32'd0, 32'd0, 0, 0, 0, 1, "err_reset");
    cyc(32'd0, 32'd0, 0, 0, 0, 0, "err_cleared");

    // Divide completing with an exception.
    cyc(32'd0, DIV_6_1_2, 0, 0, 0, 0, "div_ex_start");
    for (int i = 1; i <= 6; i++) cyc(32'd0, DIV_6_1_2, 0, (i == 6), (i == 6), 0, "div_ex_busy");
    cyc(32'd0, DIV_6_1_2, 0, 0, 0, 0, "div_ex_done");
    cyc(32'd0, 32'd0, 0, 0, 0, 0, "div_ex_idle");

    // Reset in the fifth busy cycle, then the held mul restarts.
    cyc(32'd0, MUL_4_1_2, 0, 0, 0, 0, "rst_mul_start");
    for (int i = 1; i <= 4; i++) cyc(32'd0, MUL_4_1_2, 0, 0, 0, 0, "rst_mul_busy");
    cyc(32'd0, MUL_4_1_2, 0, 0, 0, 1, "rst_mid_busy");
    cyc(32'd0, MUL_4_1_2, 0, 0, 0, 0, "rst_mul_restart");
    for (int i = 1; i <= 3; i++) cyc(32'd0, MUL_4_1_2, 0, (i == 3), 0, 0, "rst_mul_busy2");
    cyc(32'd0, MUL_4_1_2, 0, 0, 0, 0, "rst_mul_done");

    // Random instruction streams.
    cur_dx = 32'd0;
    for (int n = 0; n < 3000; n++) begin
      if (!m_op_running && !m_result_now) cur_dx = rnd_insn();
      bt = !m_op_running && ($urandom_range(0, 7) == 0);
      cyc(rnd_insn(), cur_dx, bt, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 199) == 0), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_control.md
Name: hazard_stall_control

Overview:
- Stall/flush controller for the 5-stage pipeline; works alongside the forwarding unit.
- It handles the hazards forwarding cannot cover:
  - load-use hazards, by stalling FD/PC and injecting a DX bubble;
  - taken-branch/jump wrong-path instructions, by flushing FD and DX;
  - multi-cycle mult/div, through a start/busy/done FSM that freezes the front of the pipe until the multdiv unit reports ready.
- Sits between the FD/DX/XM latches, PC register and multdiv unit.

Parameters:
- MD_TIMEOUT, 40, max BUSY cycles before a multdiv timeout error is declared.
- CNT_W, 6, width of the BUSY cycle counter; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- fd_insn  in  32  instruction in the FD latch.
- dx_insn  in  32  instruction in the DX latch.
- branch_taken  in  1  X stage resolved taken bne/blt/j/jal/jr/bex this cycle.
- multdiv_rdy  in  1  multdiv result valid, one-cycle pulse.
- multdiv_exception  in  1  multdiv overflow/div-by-0; valid with multdiv_rdy.
- stall_pc  out  1  hold PC.
- stall_fd  out  1  hold FD latch.
- stall_dx  out  1  hold DX latch.
- nop_dx  out  1  load all-zero insn into DX next edge.
- nop_xm  out  1  load all-zero insn into XM next edge.
- flush_fd  out  1  load all-zero insn into FD next edge.
- ctrl_mult  out  1  one-cycle multdiv start, multiply.
- ctrl_div  out  1  one-cycle multdiv start, divide.
- md_result_sel  out  1  X stage output takes the multdiv result.
- md_exception  out  1  the completing mult/div raised an exception (X writes r30).
- md_busy  out  1  FSM is BUSY.
- md_error  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Field decode (same for FD and DX):
  - opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
  - R-type 00000, addi 00101, sw 00111, lw 01000, bne 00010, blt 00110, jr 00100.
  - mul = R-type with ALU op 00110; div = R-type with ALU op 00111.
- Load-use (combinational), lu = DX is lw AND dx_rd != 0 AND FD reads dx_rd, where FD reads dx_rd if any of:
  - rs match, when FD is R/addi/lw/sw/bne/blt;
  - rt match, when FD is R-type but not a shift (ALU op 0010x);
  - rd match, when FD is bne/blt/jr.
- sw data (rd) after lw does NOT stall; the W->M bypass covers it.
- lu gives stall_pc = stall_fd = nop_dx = 1 for exactly one cycle. The following cycle the lw is in XM and lu is false.
- Flush: branch_taken gives flush_fd = nop_dx = 1 and forces lu stall terms to 0, because the FD instruction is wrong-path. stall_pc = 0 so the PC takes the target.
- Multdiv FSM, states IDLE, BUSY, DONE; reset puts it in IDLE with counter 0 and md_error 0.
  - IDLE, DX is mul/div: ctrl_mult or ctrl_div = 1 this cycle (Mealy); next state BUSY; counter cleared.
  - BUSY:
    - outputs: stall_pc = stall_fd = stall_dx = nop_xm = 1, md_busy = 1, counter increments;
    - multdiv_rdy = 1: go to DONE and latch multdiv_exception;
    - counter == MD_TIMEOUT-1 with no rdy: set md_error and go to DONE with exception latched 1.
  - DONE (one cycle): md_result_sel = 1, md_exception = latched value, no stalls; the mul/div advances to XM; next state IDLE.
  - DONE never starts a new op. A back-to-back mul/div is started from IDLE the next cycle, so starts are at least 3 cycles apart.
- Combining: all stall/nop outputs are OR of load-use, flush and FSM terms. nop_dx is suppressed while stall_dx = 1 (DX held). lu cannot occur during BUSY (DX holds mul/div, not lw), but the OR keeps it safe.
- branch_taken while BUSY cannot occur (DX holds mul/div); no special handling is required.
- Reset mid-BUSY: next edge goes to IDLE, all outputs 0, latched exception cleared, and no start is pulsed in the reset cycle.

Test Plan:
- FD = 0x01CA3000 (add $7,$5,$3) with DX = 0x41440000 (lw $5,0($2)) -> stall_pc = stall_fd = nop_dx = 1 for 1 cycle, then 0 when the lw reaches XM.
- FD = 0x394C0000 (sw $5,0($6)) with DX lw $5 -> no stall. FD = 0x3A0A0000 (sw $8,0($5)) with DX lw $5 -> 1-cycle stall.
- DX = lw $0 with FD reading $0 -> no stall. Same lu case with branch_taken = 1 -> flush_fd = nop_dx = 1, stall_pc = 0.
- DX = 0x01022018 (mul $4,$1,$2) -> ctrl_mult pulses 1 cycle; rdy after 16 cycles -> 16 BUSY cycles with stalls and nop_xm, then DONE 1 cycle with md_result_sel = 1, then IDLE.
- div with no rdy -> md_error set after 40 BUSY cycles, DONE with md_exception = 1, and md_error held until reset. Separately, a div completing with multdiv_exception = 1 -> md_exception = 1 in DONE.
- reset asserted at BUSY cycle 5 -> next cycle all outputs 0, state IDLE; mul still in DX after reset -> ctrl_mult pulses again.
